// File: rtl/crc32_pkg.sv
// CRC-32 shared definitions: polynomial, seed, FSM state type and the byte-step function.
// Latency: combinational helpers only; no state.
// Backpressure: not applicable.
package crc32_pkg;

    localparam logic [31:0] CRC_POLY         = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT_DEFAULT = 32'hFFFFFFFF;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Eight serial MSB-first shifts of the CRC register, non-reflected, no final xor.
    // The transmitter-side generator uses the same function, so both ends agree bit for bit.
    function automatic logic [31:0] crc32_byte_step(
        input logic [31:0] crc,
        input logic [7:0]  data_byte,
        input logic [31:0] poly
    );
        logic [31:0] c;
        c = crc ^ {data_byte, 24'h000000};
        for (int i = 0; i < 8; i++) begin
            c = c[31] ? ((c << 1) ^ poly) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_frame_checker_if.sv
// Byte-stream bundle between deserialiser, checker and (optionally) the stripped payload consumer.
// Latency: none, wires only; the out_* group exists only when CRC_STRIP_EN is defined.
// Backpressure: none; a byte is taken whenever data_valid is high.
interface crc32_frame_checker_if;

    logic [7:0] data;
    logic       data_valid;
    logic       data_last;

`ifdef CRC_STRIP_EN
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;

    modport master (output data, data_valid, data_last,
                    input  out_data, out_valid, out_last);
    modport slave  (input  data, data_valid, data_last,
                    output out_data, out_valid, out_last);
`else
    modport master (output data, data_valid, data_last);
    modport slave  (input  data, data_valid, data_last);
`endif

endinterface

// File: rtl/crc32_strip_buf.sv
// Four-deep byte delay line that drops the trailing 4 bytes (the CRC) of every frame.
// Latency: byte k is emitted one cycle after byte k+4 is accepted; last flag rides on the final emitted byte.
// Backpressure: none; advances only on valid, flushes on the last byte of a frame.
module crc32_strip_buf (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       valid,
    input  logic       last,
    output logic [7:0] dly_data,
    output logic       dly_valid,
    output logic       dly_last
);

    logic [7:0] taps [4];
    logic [2:0] fill;
    logic       full;

    assign full = (fill == 3'd4);

    // Shift accepted bytes through the taps; once four are held, each new byte pushes the oldest out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) taps[i] <= 8'h00;
            fill      <= 3'd0;
            dly_data  <= 8'h00;
            dly_valid <= 1'b0;
            dly_last  <= 1'b0;
        end else begin
            dly_valid <= valid && full;
            dly_last  <= valid && last && full;
            if (valid && full) dly_data <= taps[3];
            if (valid) begin
                taps[0] <= data;
                taps[1] <= taps[0];
                taps[2] <= taps[1];
                taps[3] <= taps[2];
                // The four bytes still held at frame end are the CRC: forget them.
                if (last)       fill <= 3'd0;
                else if (!full) fill <= fill + 3'd1;
            end
        end
    end

endmodule

// File: rtl/crc32_frame_checker.sv
// Receive-side CRC-32 frame checker with saturating good/bad counters; optional CRC strip (macro CRC_STRIP_EN).
// Latency: frame result and counters update one cycle after the last byte; stripped payload also one cycle.
// Backpressure: none; every valid byte is consumed, frames may arrive back to back.
module crc32_frame_checker
    import crc32_pkg::*;
#(
    parameter logic [31:0] POLY    = CRC_POLY,
    parameter logic [31:0] INIT    = CRC_INIT_DEFAULT,
    parameter int          MIN_LEN = 5,
    parameter int          CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    crc32_frame_checker_if.slave    stream,
    output logic                    frame_done,
    output logic                    frame_ok,
    output logic                    frame_err,
    output logic                    len_err,
    output logic [31:0]             crc_residue,
    output logic [CNT_W-1:0]        good_cnt,
    output logic [CNT_W-1:0]        bad_cnt
);

    localparam logic [15:0] MIN_LEN_W = 16'(MIN_LEN);

    state_t      state;
    state_t      state_nxt;
    logic        first_byte;
    logic        end_frame;
    logic [31:0] crc_q;
    logic [31:0] crc_base;
    logic [31:0] crc_next;
    logic [15:0] byte_cnt;
    logic [15:0] len_total;
    logic        len_short;
    logic        result_ok;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: a multi-byte frame lives in RUN; a single-byte frame completes straight from IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (stream.data_valid && !stream.data_last) state_nxt = RUN;
            RUN:     if (stream.data_valid &&  stream.data_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: seed selection for the first byte and end-of-frame strobe.
    always_comb begin
        first_byte = (state == IDLE);
        end_frame  = stream.data_valid && stream.data_last;
    end

    // CRC step and frame verdict for the byte on the bus this cycle.
    always_comb begin
        crc_base  = first_byte ? INIT : crc_q;
        crc_next  = crc32_byte_step(crc_base, stream.data, POLY);
        len_total = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;
        len_short = (len_total < MIN_LEN_W);
        result_ok = (crc_next == 32'h0) && !len_short;
    end

    // Running CRC and length; both reseed on the last byte so the next frame can follow immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q    <= INIT;
            byte_cnt <= 16'd0;
        end else if (stream.data_valid) begin
            if (stream.data_last) begin
                crc_q    <= INIT;
                byte_cnt <= 16'd0;
            end else begin
                crc_q    <= crc_next;
                byte_cnt <= len_total;
            end
        end
    end

    // One-cycle result pulses; the residue is held until the next frame completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done  <= 1'b0;
            frame_ok    <= 1'b0;
            frame_err   <= 1'b0;
            len_err     <= 1'b0;
            crc_residue <= 32'h0;
        end else begin
            frame_done <= end_frame;
            frame_ok   <= end_frame &&  result_ok;
            frame_err  <= end_frame && !result_ok;
            len_err    <= end_frame &&  len_short;
            if (end_frame) crc_residue <= crc_next;
        end
    end

    // Saturating counters, updated on the same edge as frame_done so they are current with the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else if (end_frame) begin
            if (result_ok  && (good_cnt != '1)) good_cnt <= good_cnt + CNT_W'(1);
            if (!result_ok && (bad_cnt  != '1)) bad_cnt  <= bad_cnt  + CNT_W'(1);
        end
    end

`ifdef CRC_STRIP_EN
    logic [7:0] strip_data;
    logic       strip_valid;
    logic       strip_last;

    crc32_strip_buf u_strip_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .data      (stream.data),
        .valid     (stream.data_valid),
        .last      (stream.data_last),
        .dly_data  (strip_data),
        .dly_valid (strip_valid),
        .dly_last  (strip_last)
    );

    assign stream.out_data  = strip_data;
    assign stream.out_valid = strip_valid;
    assign stream.out_last  = strip_last;
`endif

endmodule

// File: tb/tb_crc32_frame_checker.sv
// Directed bench for crc32_frame_checker: vector table plus reset, back-to-back, saturation and strip sequences.
// Latency: expects results one cycle after the last byte.
// Backpressure: none exercised; the DUT has none.
module tb_crc32_frame_checker;
    import crc32_pkg::*;

    localparam int CNT_W = 3;

    typedef logic [7:0] frame_t [16];

    typedef struct {
        frame_t      bytes;
        int          len;
        bit          gaps;
        bit          ok;
        bit          len_e;
        bit          chk_res;
        logic [31:0] res;
        int          good;
        int          bad;
    } vec_t;

    typedef struct {
        int              cyc;
        logic            ok;
        logic            err;
        logic            len_e;
        logic [31:0]     res;
        logic [CNT_W-1:0] good;
        logic [CNT_W-1:0] bad;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    crc32_frame_checker_if bus ();

    logic             frame_done;
    logic             frame_ok;
    logic             frame_err;
    logic             len_err;
    logic [31:0]      crc_residue;
    logic [CNT_W-1:0] good_cnt;
    logic [CNT_W-1:0] bad_cnt;

    crc32_frame_checker #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stream      (bus),
        .frame_done  (frame_done),
        .frame_ok    (frame_ok),
        .frame_err   (frame_err),
        .len_err     (len_err),
        .crc_residue (crc_residue),
        .good_cnt    (good_cnt),
        .bad_cnt     (bad_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every frame_done cycle with the values seen alongside it.
    ev_t evq[$];
    ev_t ev_w;
    always @(negedge clk) begin
        if (frame_done === 1'b1) begin
            ev_w.cyc   = cyc;
            ev_w.ok    = frame_ok;
            ev_w.err   = frame_err;
            ev_w.len_e = len_err;
            ev_w.res   = crc_residue;
            ev_w.good  = good_cnt;
            ev_w.bad   = bad_cnt;
            evq.push_back(ev_w);
        end
    end

`ifdef CRC_STRIP_EN
    typedef struct {
        logic [7:0] d;
        logic       l;
        int         cyc;
    } ob_t;
    ob_t oq[$];
    ob_t ob_w;
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            ob_w.d   = bus.out_data;
            ob_w.l   = bus.out_last;
            ob_w.cyc = cyc;
            oq.push_back(ob_w);
        end
    end
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic frame_t check_frame(input logic [7:0] last_b);
        frame_t f;
        f = '{default: 8'h00};
        for (int i = 0; i < 9; i++) f[i] = 8'h31 + 8'(i);
        f[9]  = 8'h03;
        f[10] = 8'h76;
        f[11] = 8'hE6;
        f[12] = last_b;
        return f;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.data_valid = 1'b0;
            bus.data_last  = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l, output int at_cyc);
        @(negedge clk);
        bus.data       = d;
        bus.data_valid = 1'b1;
        bus.data_last  = l;
        at_cyc         = cyc;
    endtask

    // With gaps set, an idle cycle with data_last=1 follows each non-final byte; it must be ignored.
    task automatic send_frame(input frame_t b, input int len, input bit gaps, output int last_cyc);
        int c;
        last_cyc = 0;
        for (int i = 0; i < len; i++) begin
            send_byte(b[i], (i == len - 1), c);
            if (i == len - 1) last_cyc = c;
            if (gaps && (i != len - 1)) begin
                @(negedge clk);
                bus.data_valid = 1'b0;
                bus.data       = 8'h00;
                bus.data_last  = 1'b1;
            end
        end
        idle(1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        bus.data_valid = 1'b0;
        bus.data_last  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
    endtask

    vec_t   vecs[6];
    frame_t f;
    int     n0;
    int     lc;
    int     lc2;
    ev_t    e;

    initial begin
        // Watchdog: the directed sequence is a few hundred cycles.
        fork
            begin
                #200000;
                $display("FAIL watchdog: simulation did not complete in time");
                $fatal(1, "watchdog expired");
            end
        join_none

        bus.data       = 8'h00;
        bus.data_valid = 1'b0;
        bus.data_last  = 1'b0;

        // Vector table: counters are cumulative from reset.
        vecs[0] = '{check_frame(8'hE7), 13, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00000000, 1, 0};
        vecs[1] = '{check_frame(8'hE6), 13, 1'b0, 1'b0, 1'b0, 1'b1, 32'h04C11DB7, 1, 1};
        f = '{default: 8'h00};
        f[0] = 8'hAA; f[1] = 8'hBB; f[2] = 8'hCC;
        vecs[2] = '{f, 3, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1, 2};
        vecs[3] = '{check_frame(8'hE7), 13, 1'b1, 1'b1, 1'b0, 1'b1, 32'h00000000, 2, 2};
        f = '{default: 8'h00};
        f[0] = 8'h5A;
        vecs[4] = '{f, 1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2, 3};
        f = '{default: 8'h00};
        f[0] = 8'h03; f[1] = 8'h76; f[2] = 8'hE6; f[3] = 8'hE7;
        vecs[5] = '{f, 4, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2, 4};

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst frame_done",  32'(frame_done),  32'h0);
        check("rst frame_ok",    32'(frame_ok),    32'h0);
        check("rst frame_err",   32'(frame_err),   32'h0);
        check("rst len_err",     32'(len_err),     32'h0);
        check("rst crc_residue", crc_residue,      32'h0);
        check("rst good_cnt",    32'(good_cnt),    32'h0);
        check("rst bad_cnt",     32'(bad_cnt),     32'h0);
`ifdef CRC_STRIP_EN
        check("rst out_valid",   32'(bus.out_valid), 32'h0);
        check("rst out_last",    32'(bus.out_last),  32'h0);
        check("rst out_data",    32'(bus.out_data),  32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);
        check("idle no frame_done", 32'(evq.size()), 32'h0);

        // Table-driven frames.
        for (int i = 0; i < 6; i++) begin
            n0 = evq.size();
            send_frame(vecs[i].bytes, vecs[i].len, vecs[i].gaps, lc);
            idle(3);
            check($sformatf("v%0d done count", i), 32'(evq.size()), 32'(n0 + 1));
            if (evq.size() > n0) begin
                e = evq[n0];
                check($sformatf("v%0d latency", i), 32'(e.cyc - lc), 32'h1);
                check($sformatf("v%0d frame_ok", i), 32'(e.ok), 32'(vecs[i].ok));
                check($sformatf("v%0d frame_err", i), 32'(e.err), 32'(!vecs[i].ok));
                check($sformatf("v%0d len_err", i), 32'(e.len_e), 32'(vecs[i].len_e));
                if (vecs[i].chk_res)
                    check($sformatf("v%0d crc_residue", i), e.res, vecs[i].res);
                check($sformatf("v%0d good_cnt", i), 32'(e.good), 32'(vecs[i].good));
                check($sformatf("v%0d bad_cnt", i), 32'(e.bad), 32'(vecs[i].bad));
            end
            check($sformatf("v%0d pulse ends", i), 32'(frame_done), 32'h0);
        end
        check("residue held", crc_residue, evq[evq.size() - 1].res);

        // Back-to-back good frames, no idle cycle between them.
        do_reset();
        check("b2b rst good_cnt", 32'(good_cnt), 32'h0);
        check("b2b rst bad_cnt",  32'(bad_cnt),  32'h0);
        n0 = evq.size();
        f = check_frame(8'hE7);
        for (int i = 0; i < 13; i++) send_byte(f[i], (i == 12), lc);
        for (int i = 0; i < 13; i++) send_byte(f[i], (i == 12), lc2);
        idle(3);
        check("b2b done count", 32'(evq.size()), 32'(n0 + 2));
        if (evq.size() >= n0 + 2) begin
            check("b2b spacing",   32'(evq[n0 + 1].cyc - evq[n0].cyc), 32'd13);
            check("b2b latency 1", 32'(evq[n0].cyc - lc), 32'h1);
            check("b2b latency 2", 32'(evq[n0 + 1].cyc - lc2), 32'h1);
            check("b2b ok 1",      32'(evq[n0].ok), 32'h1);
            check("b2b ok 2",      32'(evq[n0 + 1].ok), 32'h1);
            check("b2b good_cnt",  32'(evq[n0 + 1].good), 32'h2);
            check("b2b bad_cnt",   32'(evq[n0 + 1].bad), 32'h0);
        end

        // Reset in the middle of a frame.
        n0 = evq.size();
        for (int i = 0; i < 6; i++) send_byte(f[i], 1'b0, lc);
        @(negedge clk);
        rst_n          = 1'b0;
        bus.data_valid = 1'b0;
        bus.data_last  = 1'b0;
        @(negedge clk);
        check("midrst frame_done", 32'(frame_done), 32'h0);
        check("midrst good_cnt",   32'(good_cnt),   32'h0);
        check("midrst bad_cnt",    32'(bad_cnt),    32'h0);
        rst_n = 1'b1;
        idle(3);
        check("midrst no done", 32'(evq.size()), 32'(n0));
        send_frame(f, 13, 1'b0, lc);
        idle(3);
        check("midrst next count", 32'(evq.size()), 32'(n0 + 1));
        if (evq.size() > n0) begin
            check("midrst next ok",   32'(evq[n0].ok), 32'h1);
            check("midrst next res",  evq[n0].res, 32'h0);
            check("midrst next good", 32'(evq[n0].good), 32'h1);
            check("midrst next bad",  32'(evq[n0].bad), 32'h0);
        end

        // Saturation: nine single-byte frames back to back, then a good frame.
        do_reset();
        n0 = evq.size();
        for (int i = 0; i < 9; i++) send_byte(8'h5A, 1'b1, lc);
        idle(3);
        check("sat done count", 32'(evq.size()), 32'(n0 + 9));
        if (evq.size() >= n0 + 9) begin
            check("sat bad at 7th", 32'(evq[n0 + 6].bad), 32'h7);
            check("sat bad held",   32'(evq[n0 + 8].bad), 32'h7);
            check("sat len_err",    32'(evq[n0 + 8].len_e), 32'h1);
            check("sat good idle",  32'(evq[n0 + 8].good), 32'h0);
        end
        send_frame(f, 13, 1'b0, lc);
        idle(3);
        check("sat good_cnt after", 32'(good_cnt), 32'h1);
        check("sat bad_cnt after",  32'(bad_cnt),  32'h7);

`ifdef CRC_STRIP_EN
        // Stripped payload: bytes 31..39 only, last flag with frame_done, CRC never emitted.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            oq.delete();
            n0 = evq.size();
            send_frame(f, 13, 1'b0, lc);
            idle(3);
            check($sformatf("strip%0d count", r), 32'(oq.size()), 32'd9);
            if (oq.size() == 9) begin
                for (int i = 0; i < 9; i++) begin
                    check($sformatf("strip%0d data %0d", r, i), 32'(oq[i].d), 32'(8'h31 + 8'(i)));
                    check($sformatf("strip%0d last %0d", r, i), 32'(oq[i].l), 32'(i == 8));
                end
                if (evq.size() > n0)
                    check($sformatf("strip%0d last with done", r), 32'(oq[8].cyc), 32'(evq[n0].cyc));
            end
        end
        oq.delete();
        f = '{default: 8'h00};
        f[0] = 8'h03; f[1] = 8'h76; f[2] = 8'hE6; f[3] = 8'hE7;
        send_frame(f, 4, 1'b0, lc);
        idle(3);
        check("strip short emits nothing", 32'(oq.size()), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
